sram_controller: RTL
====================

Name: sram_controller

Overview:
- Memory-side responder for the pipeline's MEM stage: accepts the MEM stage's 32-bit word read/write requests and services them on an external 16-bit asynchronous SRAM, two half-word accesses per word.
- Deasserts ready while an access is in flight; the top level ORs ~ready into the pipeline freeze so every stage register holds.
- Replaces the single-cycle data memory inside MEM_Stage; the request inputs come straight from EXE_Stage_Reg outputs (mem_r_en, mem_w_en, alu_result, val_rm).

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 3: cycles each half-word phase is held on the SRAM bus. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_en  input  1  read request (MEM-stage mem_r_en).
- wr_en  input  1  write request (MEM-stage mem_w_en).
- address  input  32  byte address (ALU result).
- write_data  input  32  store data (val_rm).
- read_data  output  32  loaded word.
- ready  output  1  1 = no access pending, or access completing this cycle.
- sram_addr  output  18  half-word address to the SRAM.
- sram_dq_o  output  16  write data to the SRAM.
- sram_dq_i  input  16  read data from the SRAM.
- sram_dq_oe  output  1  1 = controller drives the DQ bus.
- sram_we_n  output  1  active-low SRAM write strobe.

Behaviour:
- Reset values: state IDLE, counter 0, read_data 0, sram_addr 0, sram_dq_o 0, sram_dq_oe 0, sram_we_n 1.
- Reset while an access is in flight aborts it immediately and applies the reset values. ready then follows the IDLE rule.
- Request present: req = rd_en | wr_en. If both are high, the access is a write.
- Address map: word = (address - BASE_ADDR) >> 2, truncated to 17 bits.
  - Low phase: sram_addr = {word, 1'b0}.
  - High phase: sram_addr = {word, 1'b1}.
  - address[1:0] are ignored.
- ready is combinational: ready = ~req | (state == DONE).
- The requester holds rd_en, wr_en, address and write_data stable while ready = 0.
- IDLE:
  - Bus idle: sram_we_n = 1, sram_dq_oe = 0.
  - If req is high, latch the operation type, load counter = WAIT_CYCLES-1 and go to LOW.
  - If req is low, stay in IDLE.
- LOW:
  - Drive sram_addr for the low half.
  - Write: sram_dq_o = write_data[15:0], sram_dq_oe = 1, sram_we_n = 0.
  - Read: sram_dq_oe = 0, sram_we_n = 1.
  - Counter decrements each cycle. When the counter is 0:
    - on a read, capture read_data[15:0] <= sram_dq_i;
    - reload the counter and go to HIGH.
- HIGH:
  - Same as LOW, using the high half: write_data[31:16] and read_data[31:16].
  - When the counter is 0, go to DONE.
- DONE:
  - Bus released: sram_we_n = 1, sram_dq_oe = 0.
  - ready = 1, so the pipeline advances at this edge.
  - Next state is always IDLE; a new request is not accepted in DONE.
- Latency: ready is 0 for 1 + 2*WAIT_CYCLES consecutive cycles after req rises, then 1 for one cycle (DONE).
- Back-to-back requests: the gap between accesses is exactly one IDLE cycle.
- read_data is updated only by reads. It holds its value across writes and idle cycles until the next read completes.
- req dropping mid-access is a protocol violation. The controller still completes the sequence and returns to IDLE.
- sram_addr and sram_dq_o hold their last values while in IDLE and DONE.

Test Plan:
- Idle: rd_en = wr_en = 0 for 10 cycles -> ready = 1, sram_we_n = 1, sram_dq_oe = 0 throughout.
- Write, WAIT_CYCLES = 3: wr_en = 1, address = 1024, write_data = 0xDEADBEEF.
  - ready low for exactly 7 cycles.
  - SRAM model gets half-word 0 = 0xBEEF, then half-word 1 = 0xDEAD; sram_we_n low for 3 cycles in each phase.
  - ready high for 1 cycle.
- Read-back: rd_en = 1, address = 1024 -> ready low 7 cycles; in the DONE cycle read_data = 0xDEADBEEF.
- Mapping: write 0x12345678 to address 1032 -> SRAM half-words 4 = 0x5678 and 5 = 0x1234.
  - Then read address 1035 -> read_data = 0x12345678.
- Simultaneous: rd_en = wr_en = 1, write_data = 0xA5A5_0F0F -> treated as a write (sram_we_n pulses low); read_data is unchanged.
- Reset mid-write: assert rst during the HIGH phase.
  - Next cycle: state IDLE, sram_we_n = 1, sram_dq_oe = 0, read_data = 0.
  - SRAM half-word 1 is not written after the reset edge.
  - With rst released and wr_en still high, ready stays 0 and a fresh 7-cycle access starts.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: 32-bit MEM-stage word accesses serviced as two half-word phases on a 16-bit async SRAM
module sram_controller #(
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);
  state_t state, state_n;
  logic [3:0] cnt;
  logic op_wr;
  logic req;
  logic cnt_zero;
  logic [16:0] word;
  assign req = rd_en | wr_en;
  assign cnt_zero = cnt == 4'd0;
  assign word = 17'((address - BASE_ADDR) >> 2);
  assign ready = ~req | (state == DONE);
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // each half-word phase lasts until the wait counter hits zero; DONE always returns to IDLE
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (req ? LOW : IDLE) :
              state == LOW  ? (cnt_zero ? HIGH : LOW) :
              state == HIGH ? (cnt_zero ? DONE : HIGH) : IDLE;
  end
  // bus outputs are set up on the edge entering each phase so they are stable for the whole phase
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      op_wr      <= 1'b0;
      read_data  <= 32'd0;
      sram_addr  <= 18'd0;
      sram_dq_o  <= 16'd0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (req) begin
          op_wr      <= wr_en;
          cnt        <= RELOAD;
          sram_addr  <= {word, 1'b0};
          sram_dq_oe <= wr_en;
          sram_we_n  <= ~wr_en;
          if (wr_en) sram_dq_o <= write_data[15:0];
        end
        LOW: if (cnt_zero) begin
          if (!op_wr) read_data[15:0] <= sram_dq_i;
          cnt       <= RELOAD;
          sram_addr <= {word, 1'b1};
          if (op_wr) sram_dq_o <= write_data[31:16];
        end else cnt <= cnt - 4'd1;
        HIGH: if (cnt_zero) begin
          if (!op_wr) read_data[31:16] <= sram_dq_i;
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
        end else cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end
endmodule
